multi_nch_disp: RTL and testbench

MULTI_NCH_DISP -- requirements
Module: multi_nch_disp

---
 rtl/multi_nch_disp_pkg.sv | 24 ++
 rtl/disp_scan_ctrl.sv | 82 ++++++++
 rtl/multi_nch_disp.sv | 86 ++++++++
 tb/tb_multi_nch_disp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_nch_disp_pkg.sv
// Shared display constants and a width helper for the multi-channel display slice.
// No ports: holds the default channel count, data width, scan divider,
// the decimal-point/blink field width and a ceil(log2) function.
package multi_nch_disp_pkg;

  localparam int DEF_CH       = 8;
  localparam int DEF_W        = 32;
  localparam int DEF_SCAN_DIV = 2**24;
  localparam int PT_W         = 8;

  // ceil(log2(n)); callers never pass n < 2
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl.sv
// Channel selection controller: manual select with clamp, or auto-scan that
// rotates through the channels enabled in ch_mask every SCAN_DIV cycles.
// Ports:
//   clk, rst   - clock, async active-high reset
//   auto       - 1 = auto-scan, 0 = manual (test_sel)
//   test_sel   - manual channel select, clamped to CH-1
//   ch_mask    - channels included in the auto-scan rotation
//   ch_idx     - currently selected channel
module disp_scan_ctrl
  import multi_nch_disp_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  auto,
  input  logic [clog2(CH)-1:0]  test_sel,
  input  logic [CH-1:0]         ch_mask,
  output logic [clog2(CH)-1:0]  ch_idx
);

  localparam int SW = clog2(CH);
  localparam int CW = clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ch_idx_q, ch_idx_d;
  logic [SW-1:0] sel_clamped;
  logic [SW-1:0] nxt_idx;
  logic [SW-1:0] pos;
  logic          found;
  int            p;

  assign sel_clamped = (int'(test_sel) >= CH) ? SW'(CH - 1) : test_sel;

  // Next enabled channel above ch_idx_q, wrapping; the last probe (k = CH)
  // is the current channel itself. An empty mask falls back to channel 0.
  always_comb begin
    nxt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    p       = 0;
    for (int k = 1; k <= CH; k++) begin
      p = int'(ch_idx_q) + k;
      if (p >= CH) p = p - CH;
      pos = SW'(p);
      if (!found && ch_mask[pos]) begin
        found   = 1'b1;
        nxt_idx = pos;
      end
    end
  end

  // cnt sits at 0 whenever auto is low, so entering auto mode always starts
  // a full SCAN_DIV period from the current channel.
  always_comb begin
    cnt_d    = cnt_q;
    ch_idx_d = ch_idx_q;
    if (!auto) begin
      cnt_d    = '0;
      ch_idx_d = sel_clamped;
    end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d    = '0;
      ch_idx_d = nxt_idx;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ch_idx_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ch_idx_q <= ch_idx_d;
    end
  end

  assign ch_idx = ch_idx_q;

endmodule

// File: rtl/multi_nch_disp.sv
// Multi-channel display selector. Channel 0 data comes from a CPU-written
// register; the other channels come from data_flat. The selected channel's
// data, decimal-point and blink patterns are registered onto the outputs.
// Ports:
//   clk, rst             - clock, async active-high reset
//   EN, data_in          - CPU write of the channel-0 register
//   data_flat            - per-channel data, slot n at [n*W +: W] (slot 0 unused)
//   point_in, les_in     - per-channel 8-bit decimal-point / blink patterns
//   test_sel, auto       - manual select / auto-scan enable
//   ch_mask              - auto-scan channel enables
//   disp_num, point_out, le_out, ch_out - registered selection outputs
module multi_nch_disp
  import multi_nch_disp_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int W        = DEF_W,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic [W-1:0]          data_in,
  input  logic [CH*W-1:0]       data_flat,
  input  logic [CH*PT_W-1:0]    point_in,
  input  logic [CH*PT_W-1:0]    les_in,
  input  logic [clog2(CH)-1:0]  test_sel,
  input  logic                  auto,
  input  logic [CH-1:0]         ch_mask,
  output logic [W-1:0]          disp_num,
  output logic [PT_W-1:0]       point_out,
  output logic [PT_W-1:0]       le_out,
  output logic [clog2(CH)-1:0]  ch_out
);

  localparam int SW = clog2(CH);

  logic [W-1:0]    reg0_q, reg0_d;
  logic [SW-1:0]   ch_idx;
  logic [W-1:0]    disp_q, disp_d;
  logic [PT_W-1:0] point_q, point_d;
  logic [PT_W-1:0] le_q, le_d;
  logic [SW-1:0]   ch_out_q;

  disp_scan_ctrl #(
    .CH       (CH),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .auto     (auto),
    .test_sel (test_sel),
    .ch_mask  (ch_mask),
    .ch_idx   (ch_idx)
  );

  assign reg0_d = EN ? data_in : reg0_q;

  always_comb begin
    disp_d  = data_flat[int'(ch_idx)*W +: W];
    point_d = point_in[int'(ch_idx)*PT_W +: PT_W];
    le_d    = les_in[int'(ch_idx)*PT_W +: PT_W];
    if (ch_idx == '0) disp_d = reg0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg0_q   <= '0;
      disp_q   <= '0;
      point_q  <= '0;
      le_q     <= '0;
      ch_out_q <= '0;
    end else begin
      reg0_q   <= reg0_d;
      disp_q   <= disp_d;
      point_q  <= point_d;
      le_q     <= le_d;
      ch_out_q <= ch_idx;
    end
  end

  assign disp_num  = disp_q;
  assign point_out = point_q;
  assign le_out    = le_q;
  assign ch_out    = ch_out_q;

endmodule

// File: tb/tb_multi_nch_disp.sv
module tb_multi_nch_disp;

  logic         clk;
  logic         rst;
  logic         en;
  logic [31:0]  data_in;
  logic [255:0] data_flat;
  logic [63:0]  point_in;
  logic [63:0]  les_in;
  logic [2:0]   test_sel;
  logic         auto_m;
  logic [7:0]   ch_mask;
  logic [31:0]  disp_num;
  logic [7:0]   point_out;
  logic [7:0]   le_out;
  logic [2:0]   ch_out;

  logic [159:0] data_flat5;
  logic [39:0]  point_in5;
  logic [39:0]  les_in5;
  logic [2:0]   test_sel5;
  logic [31:0]  disp_num5;
  logic [7:0]   point_out5;
  logic [7:0]   le_out5;
  logic [2:0]   ch_out5;

  int checks;
  int failures;
  logic [31:0] exp_reg0;

  multi_nch_disp #(.CH(8), .W(32), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .EN(en), .data_in(data_in), .data_flat(data_flat),
    .point_in(point_in), .les_in(les_in), .test_sel(test_sel), .auto(auto_m),
    .ch_mask(ch_mask), .disp_num(disp_num), .point_out(point_out),
    .le_out(le_out), .ch_out(ch_out)
  );

  multi_nch_disp #(.CH(5), .W(32), .SCAN_DIV(4)) dut5 (
    .clk(clk), .rst(rst), .EN(1'b0), .data_in(32'h0), .data_flat(data_flat5),
    .point_in(point_in5), .les_in(les_in5), .test_sel(test_sel5), .auto(1'b0),
    .ch_mask(5'h1F), .disp_num(disp_num5), .point_out(point_out5),
    .le_out(le_out5), .ch_out(ch_out5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input int ch);
    if (ch == 0) return exp_reg0;
    if (ch == 5) return 32'h0000_2048;
    return 32'h1000 + ch;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; data_in = 32'hDEAD_BEEF;
    auto_m = 1'b0; test_sel = 3'd0; ch_mask = 8'hFF; test_sel5 = 3'd0;
    tick(); tick();
    checks++;
    if (disp_num !== 32'h0 || point_out !== 8'h00 || le_out !== 8'h00 || ch_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold: disp=%h point=%h le=%h ch=%0d required all 0",
               disp_num, point_out, le_out, ch_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (disp_num !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_edge: disp=%h required 00000000", disp_num);
    end
    tick();
    checks++;
    if (disp_num !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL reset_en_latency: disp=%h required deadbeef", disp_num);
    end
    en = 1'b0;
    exp_reg0 = 32'hDEAD_BEEF;
  endtask

  task automatic test_manual();
    test_sel = 3'd0;
    tick(); tick();
    checks++;
    if (disp_num !== 32'hDEAD_BEEF || ch_out !== 3'd0) begin
      failures++;
      $display("FAIL manual_ch0: disp=%h ch=%0d required deadbeef ch 0", disp_num, ch_out);
    end
    test_sel = 3'd5;
    tick();
    checks++;
    if (ch_out !== 3'd0 || disp_num !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL manual_lat1: disp=%h ch=%0d required deadbeef ch 0", disp_num, ch_out);
    end
    tick();
    checks++;
    if (disp_num !== 32'h0000_2048 || point_out !== 8'h0F || le_out !== 8'hA5 || ch_out !== 3'd5) begin
      failures++;
      $display("FAIL manual_sel5: disp=%h point=%h le=%h ch=%0d required 00002048 0f a5 5",
               disp_num, point_out, le_out, ch_out);
    end
    test_sel = 3'd7;
    tick(); tick();
    checks++;
    if (disp_num !== 32'h0000_1007 || point_out !== 8'h07 || le_out !== 8'hA7 || ch_out !== 3'd7) begin
      failures++;
      $display("FAIL manual_sel7: disp=%h point=%h le=%h ch=%0d required 00001007 07 a7 7",
               disp_num, point_out, le_out, ch_out);
    end
  endtask

  task automatic test_en_ch0();
    test_sel = 3'd0;
    tick(); tick();
    en = 1'b1; data_in = 32'h1234_5678;
    tick();
    en = 1'b0; data_in = 32'hFFFF_FFFF;
    checks++;
    if (disp_num !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL en_lat1: disp=%h required deadbeef", disp_num);
    end
    tick();
    checks++;
    if (disp_num !== 32'h1234_5678) begin
      failures++;
      $display("FAIL en_lat2: disp=%h required 12345678", disp_num);
    end
    tick(); tick();
    checks++;
    if (disp_num !== 32'h1234_5678) begin
      failures++;
      $display("FAIL en_hold: disp=%h required 12345678", disp_num);
    end
    exp_reg0 = 32'h1234_5678;
  endtask

  task automatic test_clamp();
    test_sel5 = 3'd7;
    tick(); tick();
    checks++;
    if (ch_out5 !== 3'd4 || disp_num5 !== 32'h5000_0004 || point_out5 !== 8'h34) begin
      failures++;
      $display("FAIL clamp_sel7: ch=%0d disp=%h point=%h required 4 50000004 34",
               ch_out5, disp_num5, point_out5);
    end
    test_sel5 = 3'd3;
    tick(); tick();
    checks++;
    if (ch_out5 !== 3'd3 || disp_num5 !== 32'h5000_0003) begin
      failures++;
      $display("FAIL clamp_sel3: ch=%0d disp=%h required 3 50000003", ch_out5, disp_num5);
    end
  endtask

  task automatic test_auto_full();
    int exp_ch;
    test_sel = 3'd0; ch_mask = 8'hFF;
    tick(); tick();
    auto_m = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      exp_ch = ((i - 1) / 4) % 8;
      checks++;
      if (ch_out !== 3'(exp_ch) || disp_num !== exp_data(exp_ch)) begin
        failures++;
        $display("FAIL auto_full[%0d]: ch=%0d disp=%h required ch %0d disp %h",
                 i, ch_out, disp_num, exp_ch, exp_data(exp_ch));
      end
    end
    auto_m = 1'b0;
  endtask

  task automatic test_auto_mask();
    int seq[5];
    int exp_ch;
    seq = '{0, 2, 7, 2, 7};
    test_sel = 3'd0;
    tick(); tick();
    ch_mask = 8'b1000_0100;
    auto_m = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_ch = seq[(i - 1) / 4];
      checks++;
      if (ch_out !== 3'(exp_ch)) begin
        failures++;
        $display("FAIL auto_mask[%0d]: ch=%0d required %0d", i, ch_out, exp_ch);
      end
    end
    ch_mask = 8'h00;
    for (int i = 21; i <= 32; i++) begin
      tick();
      exp_ch = (i <= 24) ? 2 : 0;
      checks++;
      if (ch_out !== 3'(exp_ch)) begin
        failures++;
        $display("FAIL auto_mask_zero[%0d]: ch=%0d required %0d", i, ch_out, exp_ch);
      end
    end
    auto_m = 1'b0;
    ch_mask = 8'hFF;
  endtask

  task automatic test_toggle_and_reset();
    test_sel = 3'd0; ch_mask = 8'hFF;
    tick(); tick();
    auto_m = 1'b1;
    tick(); tick();
    auto_m = 1'b0; test_sel = 3'd3;
    tick(); tick();
    checks++;
    if (ch_out !== 3'd3) begin
      failures++;
      $display("FAIL toggle_manual: ch=%0d required 3", ch_out);
    end
    auto_m = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (ch_out !== ((i <= 4) ? 3'd3 : 3'd4)) begin
        failures++;
        $display("FAIL toggle_reenter[%0d]: ch=%0d required %0d", i, ch_out, (i <= 4) ? 3 : 4);
      end
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (disp_num !== 32'h0 || point_out !== 8'h00 || le_out !== 8'h00 || ch_out !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: disp=%h point=%h le=%h ch=%0d required all 0",
               disp_num, point_out, le_out, ch_out);
    end
    tick();
    rst = 1'b0;
    exp_reg0 = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (ch_out !== ((i <= 4) ? 3'd0 : 3'd1) || disp_num !== exp_data((i <= 4) ? 0 : 1)) begin
        failures++;
        $display("FAIL reset_restart[%0d]: ch=%0d disp=%h required ch %0d", i, ch_out, disp_num,
                 (i <= 4) ? 0 : 1);
      end
    end
    auto_m = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_reg0 = 32'h0;
    for (int n = 0; n < 8; n++) begin
      data_flat[n*32 +: 32] = 32'h1000 + n;
      point_in[n*8 +: 8]    = 8'(n);
      les_in[n*8 +: 8]      = 8'hA0 + 8'(n);
    end
    data_flat[31:0]  = 32'hBAD0_0000;
    data_flat[191:160] = 32'h0000_2048;
    point_in[47:40]  = 8'h0F;
    for (int n = 0; n < 5; n++) begin
      data_flat5[n*32 +: 32] = 32'h5000_0000 + n;
      point_in5[n*8 +: 8]    = 8'h30 + 8'(n);
      les_in5[n*8 +: 8]      = 8'hC0 + 8'(n);
    end
    test_reset();
    test_manual();
    test_en_ch0();
    test_clamp();
    test_auto_full();
    test_auto_mask();
    test_toggle_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
